// File: rtl/alu_result_stage_if.sv
// Interface between the ALU result stage and its controller: capture handshake,
// register-transfer commands, bus selects and observed register state.
interface alu_result_stage_if #(
  parameter int unsigned OP_W = 4
);
  // Capture request
  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] op;
  logic [63:0]     C;

  // HI/LO transfer commands and bus selects
  logic            hi_in;
  logic            lo_in;
  logic            zlo_out;
  logic            zhi_out;
  logic            hi_out;
  logic            lo_out;

  // Datapath bus
  logic [31:0]     bus_data;
  logic            bus_drive;

  // Register state and status
  logic [31:0]     z_hi;
  logic [31:0]     z_lo;
  logic [31:0]     hi_q;
  logic [31:0]     lo_q;
  logic            busy;
  logic            done;
  logic            err;

  modport master (
    output in_valid, op, C,
    output hi_in, lo_in, zlo_out, zhi_out, hi_out, lo_out,
    input  in_ready, bus_data, bus_drive,
    input  z_hi, z_lo, hi_q, lo_q, busy, done, err
  );

  modport slave (
    input  in_valid, op, C,
    input  hi_in, lo_in, zlo_out, zhi_out, hi_out, lo_out,
    output in_ready, bus_data, bus_drive,
    output z_hi, z_lo, hi_q, lo_q, busy, done, err
  );
endinterface

// File: rtl/alu_result_stage.sv
// ALU result stage: captures the 64-bit ALU result into Z (with a settle delay
// for MUL/DIV), transfers Z into HI/LO and drives one register onto the bus.
module alu_result_stage #(
  parameter int unsigned MULDIV_WAIT = 2,
  parameter int unsigned OP_W        = 4
) (
  input  logic               clk,
  input  logic               clr,
  alu_result_stage_if.slave  bus
);

  localparam int unsigned CNT_W    = (MULDIV_WAIT > 0) ? (($clog2(MULDIV_WAIT + 1) > 0) ? $clog2(MULDIV_WAIT + 1) : 1) : 1;
  localparam logic [OP_W-1:0] OP_MUL   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_DIV   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_LAST  = OP_W'(12);
  localparam logic [CNT_W-1:0] CNT_LOAD = (MULDIV_WAIT > 0) ? CNT_W'(MULDIV_WAIT - 1) : '0;

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [31:0]        z_hi_q,  z_hi_d;
  logic [31:0]        z_lo_q,  z_lo_d;
  logic [31:0]        hi_q,    hi_d;
  logic [31:0]        lo_q,    lo_d;
  logic               done_q,  done_d;
  logic               err_q,   err_d;

  logic               op_legal;
  logic               op_muldiv;

  assign op_legal  = (bus.op <= OP_LAST);
  assign op_muldiv = (bus.op == OP_MUL) || (bus.op == OP_DIV);

  // State and datapath registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      z_hi_q  <= '0;
      z_lo_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      z_hi_q  <= z_hi_d;
      z_lo_q  <= z_lo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state, capture and HI/LO transfer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    z_hi_d  = z_hi_q;
    z_lo_d  = z_lo_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    hi_d    = bus.hi_in ? z_hi_q : hi_q;
    lo_d    = bus.lo_in ? z_lo_q : lo_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (!op_legal) begin
            err_d = 1'b1;
          end else if (op_muldiv && (MULDIV_WAIT > 0)) begin
            cnt_d   = CNT_LOAD;
            state_d = SETTLE;
          end else begin
            z_hi_d = bus.C[63:32];
            z_lo_d = bus.C[31:0];
            done_d = 1'b1;
          end
        end
      end
      SETTLE: begin
        // New requests are not queued while the MUL/DIV result settles
        if (cnt_q == '0) begin
          z_hi_d  = bus.C[63:32];
          z_lo_d  = bus.C[31:0];
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus read mux, fixed priority zlo > zhi > lo > hi
  always_comb begin
    bus.bus_data = 32'd0;
    if (bus.zlo_out)      bus.bus_data = z_lo_q;
    else if (bus.zhi_out) bus.bus_data = z_hi_q;
    else if (bus.lo_out)  bus.bus_data = lo_q;
    else if (bus.hi_out)  bus.bus_data = hi_q;
  end

  assign bus.bus_drive = bus.zlo_out | bus.zhi_out | bus.lo_out | bus.hi_out;
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q == SETTLE);
  assign bus.z_hi      = z_hi_q;
  assign bus.z_lo      = z_lo_q;
  assign bus.hi_q      = hi_q;
  assign bus.lo_q      = lo_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage with MULDIV_WAIT=2 and hand-computed expectations.
module tb_alu_result_stage;

  localparam int unsigned OP_W = 4;

  logic clk;
  logic clr;
  int   checks;
  int   errors;

  alu_result_stage_if #(.OP_W(OP_W)) intf ();

  alu_result_stage #(.MULDIV_WAIT(2), .OP_W(OP_W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (intf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clr           = 1'b1;
    intf.in_valid = 1'b0;
    intf.op       = '0;
    intf.C        = '0;
    intf.hi_in    = 1'b0;
    intf.lo_in    = 1'b0;
    intf.zlo_out  = 1'b0;
    intf.zhi_out  = 1'b0;
    intf.hi_out   = 1'b0;
    intf.lo_out   = 1'b0;

    #12;
    check("rst_z_hi", 64'(intf.z_hi), 64'd0);
    check("rst_z_lo", 64'(intf.z_lo), 64'd0);
    check("rst_busy", 64'(intf.busy), 64'd0);
    check("rst_done", 64'(intf.done), 64'd0);
    check("rst_bus_drive", 64'(intf.bus_drive), 64'd0);
    clr = 1'b0;
    tick();
    check("rst_in_ready", 64'(intf.in_ready), 64'd1);

    // Single-cycle op
    intf.op = 4'b0000; intf.C = 64'h0000_0000_0000_00F0; intf.in_valid = 1'b1;
    tick();
    intf.in_valid = 1'b0;
    check("sc_z_lo", 64'(intf.z_lo), 64'h0000_00F0);
    check("sc_z_hi", 64'(intf.z_hi), 64'd0);
    check("sc_done", 64'(intf.done), 64'd1);
    check("sc_in_ready", 64'(intf.in_ready), 64'd1);
    tick();
    check("sc_done_clear", 64'(intf.done), 64'd0);

    // MUL with two settle cycles
    intf.op = 4'b0110; intf.C = 64'h0000_0001_FFFF_FFFE; intf.in_valid = 1'b1;
    tick();
    intf.in_valid = 1'b0;
    check("mul_busy1", 64'(intf.busy), 64'd1);
    check("mul_in_ready1", 64'(intf.in_ready), 64'd0);
    check("mul_z_lo_held", 64'(intf.z_lo), 64'h0000_00F0);
    tick();
    check("mul_busy2", 64'(intf.busy), 64'd1);
    check("mul_done_early", 64'(intf.done), 64'd0);
    tick();
    check("mul_busy_end", 64'(intf.busy), 64'd0);
    check("mul_done", 64'(intf.done), 64'd1);
    check("mul_z_hi", 64'(intf.z_hi), 64'h0000_0001);
    check("mul_z_lo", 64'(intf.z_lo), 64'hFFFF_FFFE);
    tick();
    check("mul_done_clear", 64'(intf.done), 64'd0);

    // DIV with a request presented during SETTLE
    intf.op = 4'b0111; intf.C = 64'h0000_0003_0000_0004; intf.in_valid = 1'b1;
    tick();
    intf.op = 4'b0000; intf.C = 64'h0000_0000_0000_0005;
    tick();
    check("div_ignored_z_lo", 64'(intf.z_lo), 64'hFFFF_FFFE);
    check("div_busy", 64'(intf.busy), 64'd1);
    check("div_done_early", 64'(intf.done), 64'd0);
    intf.in_valid = 1'b0; intf.op = 4'b0111; intf.C = 64'h0000_0003_0000_0004;
    tick();
    check("div_done", 64'(intf.done), 64'd1);
    check("div_z", {intf.z_hi, intf.z_lo}, 64'h0000_0003_0000_0004);
    tick();
    check("div_done_once", 64'(intf.done), 64'd0);
    check("div_in_ready", 64'(intf.in_ready), 64'd1);

    // Illegal op keeps Z
    intf.op = 4'b0001; intf.C = 64'h0000_0000_0000_00F0; intf.in_valid = 1'b1;
    tick();
    intf.op = 4'b1110; intf.C = 64'h1234_5678_9ABC_DEF0;
    tick();
    intf.in_valid = 1'b0;
    check("ill_err", 64'(intf.err), 64'd1);
    check("ill_done", 64'(intf.done), 64'd0);
    check("ill_z_lo", 64'(intf.z_lo), 64'h0000_00F0);
    check("ill_busy", 64'(intf.busy), 64'd0);
    tick();
    check("ill_err_clear", 64'(intf.err), 64'd0);

    // HI/LO transfer on the same edge as a capture sees the old Z
    intf.op = 4'b0000; intf.C = 64'h0000_0001_0000_0002; intf.in_valid = 1'b1;
    tick();
    intf.C = 64'h0000_0007_0000_0009; intf.hi_in = 1'b1; intf.lo_in = 1'b1;
    tick();
    intf.in_valid = 1'b0; intf.hi_in = 1'b0; intf.lo_in = 1'b0;
    check("hl_hi_q", 64'(intf.hi_q), 64'd1);
    check("hl_lo_q", 64'(intf.lo_q), 64'd2);
    check("hl_z", {intf.z_hi, intf.z_lo}, 64'h0000_0007_0000_0009);
    intf.lo_out = 1'b1;
    #1;
    check("bus_lo", 64'(intf.bus_data), 64'd2);
    check("bus_drive_lo", 64'(intf.bus_drive), 64'd1);
    intf.hi_out = 1'b1;
    #1;
    check("bus_lo_over_hi", 64'(intf.bus_data), 64'd2);
    intf.zhi_out = 1'b1;
    #1;
    check("bus_zhi_over_lo", 64'(intf.bus_data), 64'd7);
    intf.zlo_out = 1'b1;
    #1;
    check("bus_zlo_top", 64'(intf.bus_data), 64'd9);
    intf.zlo_out = 1'b0; intf.zhi_out = 1'b0; intf.lo_out = 1'b0;
    #1;
    check("bus_hi", 64'(intf.bus_data), 64'd1);
    intf.hi_out = 1'b0;
    #1;
    check("bus_none", 64'(intf.bus_data), 64'd0);
    check("bus_drive_none", 64'(intf.bus_drive), 64'd0);

    // Reset during MUL SETTLE abandons the capture
    intf.op = 4'b0110; intf.C = 64'h0000_00AA_0000_00BB; intf.in_valid = 1'b1;
    tick();
    intf.in_valid = 1'b0;
    check("rs_busy", 64'(intf.busy), 64'd1);
    #2;
    clr = 1'b1;
    #1;
    check("rs_z", {intf.z_hi, intf.z_lo}, 64'd0);
    check("rs_hilo", {intf.hi_q, intf.lo_q}, 64'd0);
    check("rs_busy_clr", 64'(intf.busy), 64'd0);
    check("rs_done_clr", 64'(intf.done), 64'd0);
    tick();
    clr = 1'b0;
    tick();
    check("rs_done_after1", 64'(intf.done), 64'd0);
    check("rs_in_ready", 64'(intf.in_ready), 64'd1);
    tick();
    check("rs_done_after2", 64'(intf.done), 64'd0);
    check("rs_z_after", {intf.z_hi, intf.z_lo}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
